fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: FIFO read-data width per lane.
REQ-002 SHALL have parameter PACK, default 2, legal range 2..8: FIFO words packed per output word.
REQ-003 SHALL have port clk_r, input, 1: the single clock, the FIFO read-side clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port empty, input, 1: FIFO empty flag.
REQ-006 SHALL have port en_r, output, 1: FIFO read enable.
REQ-007 SHALL have port data_r, input, WIDTH: FIFO read data, registered; valid the cycle after en_r && !empty.
REQ-008 SHALL have port flush, input, 1: single-cycle pulse requesting emission of a partial word.
REQ-009 SHALL have port out_data, output, WIDTH*PACK: packed word; lane 0 is the LSBs.
REQ-010 SHALL have port out_cnt, output, $clog2(PACK)+1: number of valid lanes in out_data.
REQ-011 SHALL have port out_valid, output, 1: output word available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the word when out_valid && out_ready.

Function
REQ-013 SHALL keep internal state lane_cnt (0..PACK), pend (1 bit, read in flight), flush_pend (1 bit) and an output register (out_data, out_cnt, out_valid).
REQ-014 SHALL drive en_r combinationally = !empty && !flush_pend && (lane_cnt + pend < PACK).
REQ-015 SHALL set pend to the value of (en_r && !empty) on the next clock edge.
REQ-016 SHALL, when pend=1, write data_r into lane lane_cnt and increment lane_cnt; data_r SHALL be ignored when pend=0.
REQ-017 SHALL treat lane_cnt==PACK as an assembled full word.
REQ-018 SHALL move a full word into the output register on the edge where the output register is free or being drained (!out_valid || out_ready), setting out_cnt=PACK and lane_cnt=0.
REQ-019 SHALL hold a full word in assembly while the output register is blocked; no data SHALL be lost or overwritten.
REQ-020 SHALL allow a capture into lane 0 in the same cycle a full word transfers out.
REQ-021 SHALL hold out_data and out_cnt stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after acceptance unless a new word is loaded on the same edge.
REQ-023 SHALL preserve word order: the FIFO read order equals the output lane order and the word order.
REQ-024 SHALL, on flush, set flush_pend=1; flush pulses arriving while flush_pend=1 are absorbed.
REQ-025 SHALL resolve a pending flush once pend=0 and the output register is free or being drained:
  - if lane_cnt>0, load lane_cnt lanes, with upper lanes zero and out_cnt=lane_cnt;
  - if lane_cnt==0, emit nothing;
  - in both cases, lane_cnt=0 and flush_pend=0.
REQ-026 SHALL give a flush arriving while lane_cnt==PACK the full-word move priority (out_cnt=PACK); the flush then resolves with lane_cnt==0.
REQ-027 SHALL have a latency of 2 clocks from en_r (at the completing read) to out_valid when the output register is free.
REQ-028 SHALL sustain throughput of one FIFO read per clock while out_ready=1.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear out_valid, out_data, out_cnt, lane_cnt, pend and flush_pend to 0.
REQ-030 SHALL discard a read in flight at reset.
REQ-031 SHALL hold en_r=0 while rst=1.
REQ-032 SHALL give reset priority over every other event, including mid-word and mid-flush.

Configuration
REQ-033 SHALL, with FIFO_RD_PARITY_EN defined, add output out_par (1 bit) = XOR of all out_data bits, registered with out_data and held under backpressure; out_par SHALL reset to 0.
REQ-034 SHALL, without FIFO_RD_PARITY_EN, omit the out_par port and parity logic and leave all other behaviour identical.

Verification (WIDTH=4, PACK=2)
REQ-035 SHALL cover: FIFO holds 0x3, 0xA, out_ready=1 -> single out_valid cycle with out_data=0xA3, out_cnt=2.
REQ-036 SHALL cover: nibbles 0x1..0x6 queued, out_ready=0 for 10 cycles -> en_r stops after 4 reads; after release -> 0x21, 0x43, 0x65 in order.
REQ-037 SHALL cover: nibble 0x7 then flush -> out_data=0x07, out_cnt=1; en_r low while flush_pend=1.
REQ-038 SHALL cover: flush with lane_cnt=0 and no read in flight -> no out_valid for 5 cycles, then en_r resumes.
REQ-039 SHALL cover: rst pulsed the cycle after en_r -> out_valid=0 and stale nibble dropped; then 0x5, 0x6 -> out_data=0x65.
REQ-040 SHALL cover, with FIFO_RD_PARITY_EN defined: out_data=0xA3 -> out_par=0; out_data=0x07 -> out_par=1.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: reads WIDTH-bit words from a FIFO with a registered read
// port and packs PACK of them into one WIDTH*PACK output word. Lane 0 holds
// the first word read. A flush pulse emits a partially filled word with its
// upper lanes zeroed. The output register uses a valid/ready handshake.
//
// Optional feature: define FIFO_RD_PARITY_EN to add out_par, the XOR of all
// out_data bits, registered together with out_data.
module fifo_rd_packer #(
  parameter int WIDTH = 4,
  parameter int PACK  = 2
) (
  input  logic                      clk_r,
  input  logic                      rst,
  input  logic                      empty,
  output logic                      en_r,
  input  logic [WIDTH-1:0]          data_r,
  input  logic                      flush,
  output logic [WIDTH*PACK-1:0]     out_data,
  output logic [$clog2(PACK):0]     out_cnt,
  output logic                      out_valid,
`ifdef FIFO_RD_PARITY_EN
  output logic                      out_par,
`endif
  input  logic                      out_ready
);

  localparam int CW = $clog2(PACK) + 1;
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  // Assembly state
  logic [CW-1:0]         lane_cnt;
  logic                  pend;
  logic                  flush_pend;
  logic [WIDTH-1:0]      lanes [PACK];

  // Per-cycle decisions
  logic                  full;
  logic                  out_free;
  logic                  move;
  logic                  resolve;
  logic                  capture;
  logic [CW-1:0]         wr_idx;
  logic [WIDTH*PACK-1:0] asm_word;

`ifdef FIFO_RD_PARITY_EN
  function automatic logic word_parity(input logic [WIDTH*PACK-1:0] w);
    return ^w;
  endfunction
`endif

  assign full     = (lane_cnt == PACK_C);
  assign out_free = !out_valid || out_ready;
  // A complete word always leaves before a pending flush is considered.
  assign move     = full && out_free;
  // A flush waits for the last in-flight read to land so no word is split.
  assign resolve  = flush_pend && !pend && out_free && !full;
  // Returning read data is only written when there is a free lane for it.
  assign capture  = pend && (!full || move);
  // When a full word leaves on this edge the new data starts a fresh word.
  assign wr_idx   = move ? '0 : lane_cnt;

  // Only issue a read if a lane is reserved for it, counting the read in flight.
  assign en_r = !rst && !empty && !flush_pend &&
                (({1'b0, lane_cnt} + {{CW{1'b0}}, pend}) < {1'b0, PACK_C});

  // Build the word to load: valid lanes only, upper lanes forced to zero.
  always_comb begin
    asm_word = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CW'(i) < lane_cnt) begin
        asm_word[i*WIDTH +: WIDTH] = lanes[i];
      end
    end
  end

  // ---- stage p1: capture returning FIFO data into its lane ----
  // Lane storage: data only, no reset needed because lane_cnt gates its use.
  always_ff @(posedge clk_r) begin
    for (int i = 0; i < PACK; i++) begin
      if (!rst && capture && (wr_idx == CW'(i))) begin
        lanes[i] <= data_r;
      end
    end
  end

  // Control: read-in-flight tracking, lane counting and flush bookkeeping.
  always_ff @(posedge clk_r) begin
    if (rst) begin
      pend       <= 1'b0;
      lane_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      pend <= en_r && !empty;
      if (move) begin
        lane_cnt <= capture ? CW'(1) : '0;
      end else if (resolve) begin
        lane_cnt <= '0;
      end else if (capture) begin
        lane_cnt <= lane_cnt + CW'(1);
      end
      // Extra flush pulses while one is outstanding are absorbed.
      flush_pend <= resolve ? 1'b0 : (flush_pend | flush);
    end
  end

  // ---- stage p2: output register with valid/ready handshake ----
  // Loads a full or flushed partial word when the register is free or draining.
  always_ff @(posedge clk_r) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
`ifdef FIFO_RD_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (move) begin
      out_valid <= 1'b1;
      out_data  <= asm_word;
      out_cnt   <= PACK_C;
`ifdef FIFO_RD_PARITY_EN
      out_par   <= word_parity(asm_word);
`endif
    end else if (resolve && (lane_cnt != '0)) begin
      out_valid <= 1'b1;
      out_data  <= asm_word;
      out_cnt   <= lane_cnt;
`ifdef FIFO_RD_PARITY_EN
      out_par   <= word_parity(asm_word);
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer (WIDTH=4, PACK=2). A small FIFO model with a
// registered read port feeds the DUT; expected words are queued as stimulus
// is issued and a monitor compares every accepted output word.
module tb_fifo_rd_packer;

  logic       clk;
  logic       rst;
  logic       empty;
  logic       en_r;
  logic [3:0] data_r;
  logic       flush;
  logic [7:0] out_data;
  logic [1:0] out_cnt;
  logic       out_valid;
  logic       out_ready;
`ifdef FIFO_RD_PARITY_EN
  logic       out_par;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO model storage
  logic [3:0] mem [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  logic [9:0] exp_q [$];
  logic [9:0] mon_e;

  fifo_rd_packer #(.WIDTH(4), .PACK(2)) dut (
    .clk_r    (clk),
    .rst      (rst),
    .empty    (empty),
    .en_r     (en_r),
    .data_r   (data_r),
    .flush    (flush),
    .out_data (out_data),
    .out_cnt  (out_cnt),
    .out_valid(out_valid),
`ifdef FIFO_RD_PARITY_EN
    .out_par  (out_par),
`endif
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty = (rd_ptr == wr_ptr);

  // Registered FIFO read port; idle cycles present junk to catch misuse.
  always @(posedge clk) begin
    if (en_r && !empty) begin
      data_r <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end else begin
      data_r <= 4'hF;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    mem[wr_ptr % 64] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_word(input logic [7:0] d, input logic [1:0] c);
    exp_q.push_back({c, d});
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: compare every accepted word against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got data=0x%02h cnt=%0d, required no word", out_data, out_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_cnt, out_data} !== mon_e) begin
          n_fail++;
          $display("FAIL out_word: got data=0x%02h cnt=%0d, required data=0x%02h cnt=%0d",
                   out_data, out_cnt, mon_e[7:0], mon_e[9:8]);
        end
`ifdef FIFO_RD_PARITY_EN
        n_tests++;
        if (out_par !== ^mon_e[7:0]) begin
          n_fail++;
          $display("FAIL out_par: got %0b for data 0x%02h, required %0b", out_par, mon_e[7:0], ^mon_e[7:0]);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int vcnt;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_cnt", int'(out_cnt), 0);
    check("rst_en_r", int'(en_r), 0);
    tick();
    rst = 1'b0;
    tick();

    // Two nibbles pack into one full word
    push(4'h3); push(4'hA);
    expect_word(8'hA3, 2'd2);
    repeat (8) tick();

    // Backpressure: only four reads fit, then release in order
    out_ready = 1'b0;
    start = rd_ptr;
    for (int i = 1; i <= 6; i++) push(4'(i));
    repeat (10) tick();
    check("stall_reads", rd_ptr - start, 4);
    check("stall_en_r", int'(en_r), 0);
    check("stall_valid", int'(out_valid), 1);
    check("stall_data_held", int'(out_data), 8'h21);
    expect_word(8'h21, 2'd2);
    expect_word(8'h43, 2'd2);
    expect_word(8'h65, 2'd2);
    out_ready = 1'b1;
    repeat (12) tick();

    // Single nibble then flush emits a partial word; reads pause meanwhile
    push(4'h7);
    expect_word(8'h07, 2'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push(4'h8);
    @(negedge clk);
    check("flush_pend_en_r", int'(en_r), 0);
    repeat (4) tick();
    push(4'h9);
    expect_word(8'h98, 2'd2);
    repeat (8) tick();

    // Flush with nothing assembled emits nothing, then reads resume
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("empty_flush_no_word", vcnt, 0);
    tick();
    push(4'hB); push(4'hC);
    expect_word(8'hCB, 2'd2);
    @(negedge clk);
    check("resume_en_r", int'(en_r), 1);
    repeat (8) tick();

    // Flush while a full word is blocked: full word wins, no partial follows
    out_ready = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    expect_word(8'h21, 2'd2);
    expect_word(8'h43, 2'd2);
    out_ready = 1'b1;
    repeat (10) tick();

    // Reset with a read in flight drops the stale nibble
    push(4'h9);
    tick();
    rst = 1'b1;
    push(4'h5); push(4'h6);
    @(negedge clk);
    check("rst_holds_en_r", int'(en_r), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", int'(out_valid), 0);
    expect_word(8'h65, 2'd2);

    // Drain with a bounded wait
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
